// File: rtl/cpu_fsm_ctrl_if.sv
// Handshake and datapath-control bundle between the instruction source and cpu_fsm_ctrl.
// The host drives s/in; the controller drives every strobe and select.
interface cpu_fsm_ctrl_if #(
    parameter int data_width = 16
);
    logic                  s;
    logic [15:0]           in;
    logic                  w;
    logic [2:0]            readnum;
    logic [2:0]            writenum;
    logic                  write;
    logic                  loada;
    logic                  loadb;
    logic                  loadc;
    logic                  loads;
    logic                  asel;
    logic                  bsel;
    logic [1:0]            vsel;
    logic [1:0]            shift;
    logic [1:0]            aluop;
    logic [data_width-1:0] sximm8;
    logic                  err;

    modport master (
        output s, in,
        input  w, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, aluop, sximm8, err
    );

    modport slave (
        input  s, in,
        output w, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, aluop, sximm8, err
    );
endinterface

// File: rtl/cpu_fsm_ctrl.sv
// Moore controller sequencing regfile, A/B/C/status loads and ALU for one instruction per start.
// Define CPU_ILLEGAL_TRAP_EN to trap undecodable opcodes in a sticky ERR state (err=1).
module cpu_fsm_ctrl #(
    parameter int data_width = 16
) (
    input logic           clk,
    input logic           rst_n,
    cpu_fsm_ctrl_if.slave bus
);
    localparam logic [2:0] WAIT   = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] WR_IMM = 3'd2;
    localparam logic [2:0] GET_A  = 3'd3;
    localparam logic [2:0] GET_B  = 3'd4;
    localparam logic [2:0] ALU    = 3'd5;
    localparam logic [2:0] WR_REG = 3'd6;
`ifdef CPU_ILLEGAL_TRAP_EN
    localparam logic [2:0] ERR    = 3'd7;
`endif

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [15:0] ir;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;
    logic       is_cmp;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign rm     = ir[2:0];
    assign is_cmp = (opcode == 3'b101) && (op == 2'b01);

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == WAIT && bus.s) ir <= bus.in;
        end
    end

    // Dispatch on the {opcode, op} pair; anything unlisted is a NOP or a trap.
    always_comb begin
        next_state = WAIT;
        case (state)
            WAIT:   next_state = bus.s ? DECODE : WAIT;
            DECODE: begin
                case ({opcode, op})
                    5'b110_10:                     next_state = WR_IMM;
                    5'b110_00, 5'b101_11:          next_state = GET_B;
                    5'b101_00, 5'b101_01, 5'b101_10: next_state = GET_A;
`ifdef CPU_ILLEGAL_TRAP_EN
                    default:                       next_state = ERR;
`else
                    default:                       next_state = WAIT;
`endif
                endcase
            end
            GET_A:  next_state = GET_B;
            GET_B:  next_state = ALU;
            ALU:    next_state = is_cmp ? WAIT : WR_REG;
            WR_IMM: next_state = WAIT;
            WR_REG: next_state = WAIT;
`ifdef CPU_ILLEGAL_TRAP_EN
            ERR:    next_state = ERR;
`endif
            default: next_state = WAIT;
        endcase
    end

    // NOTE: every output gets a default before the case, so no path leaves one unassigned (no latches).
    always_comb begin
        bus.readnum  = 3'd0;
        bus.writenum = 3'd0;
        bus.write    = 1'b0;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;
        bus.asel     = 1'b0;
        bus.vsel     = 2'b00;
        case (state)
            GET_A: begin
                bus.readnum = rn;
                bus.loada   = 1'b1;
            end
            GET_B: begin
                bus.readnum = rm;
                bus.loadb   = 1'b1;
            end
            ALU: begin
                if (is_cmp) begin
                    bus.loads = 1'b1;
                end else begin
                    bus.loadc = 1'b1;
                    // MOV reg passes B through the ALU by zeroing the A operand.
                    bus.asel  = (opcode == 3'b110);
                end
            end
            WR_IMM: begin
                bus.writenum = rn;
                bus.vsel     = 2'b10;
                bus.write    = 1'b1;
            end
            WR_REG: begin
                bus.writenum = rd;
                bus.vsel     = 2'b00;
                bus.write    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.w      = (state == WAIT);
    assign bus.bsel   = 1'b0;
    assign bus.shift  = ir[4:3];
    assign bus.aluop  = ir[12:11];
    assign bus.sximm8 = {{(data_width-8){ir[7]}}, ir[7:0]};
`ifdef CPU_ILLEGAL_TRAP_EN
    assign bus.err    = (state == ERR);
`else
    assign bus.err    = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_fsm_ctrl.sv
// Scoreboard bench for cpu_fsm_ctrl: stimulus queues expected strobe cycles, a monitor pops them.
module tb_cpu_fsm_ctrl;
    logic clk;
    logic rst_n;

    cpu_fsm_ctrl_if #(.data_width(16)) bus ();

    cpu_fsm_ctrl #(.data_width(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        write;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic        bsel;
        logic [1:0]  vsel;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic [15:0] sximm8;
    } obs_t;

    obs_t        exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] ctx_sx;
    logic [1:0]  ctx_sh;
    logic [1:0]  ctx_op;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.write    = bus.write;
        o.loada    = bus.loada;
        o.loadb    = bus.loadb;
        o.loadc    = bus.loadc;
        o.loads    = bus.loads;
        o.asel     = bus.asel;
        o.bsel     = bus.bsel;
        o.vsel     = bus.vsel;
        o.readnum  = bus.readnum;
        o.writenum = bus.writenum;
        o.shift    = bus.shift;
        o.aluop    = bus.aluop;
        o.sximm8   = bus.sximm8;
        return o;
    endfunction

    task automatic set_ctx(input logic [15:0] sx, input logic [1:0] sh, input logic [1:0] op);
        ctx_sx = sx;
        ctx_sh = sh;
        ctx_op = op;
    endtask

    // strb = {write, loada, loadb, loadc, loads}
    task automatic exp_step(input logic [4:0] strb, input logic [2:0] rn, input logic [2:0] wn,
                            input logic asel, input logic [1:0] vsel);
        obs_t e;
        e = '0;
        {e.write, e.loada, e.loadb, e.loadc, e.loads} = strb;
        e.readnum  = rn;
        e.writenum = wn;
        e.asel     = asel;
        e.vsel     = vsel;
        e.shift    = ctx_sh;
        e.aluop    = ctx_op;
        e.sximm8   = ctx_sx;
        exp_q.push_back(e);
    endtask

    // Monitor: any cycle with a strobe high must match the next queued expectation.
    initial begin
        obs_t o;
        obs_t e;
        forever begin
            @(negedge clk);
            o = sample();
            if (rst_n && (o.write | o.loada | o.loadb | o.loadc | o.loads)) begin
                if (exp_q.size() == 0) begin
                    check("spurious strobe", {o.write, o.loada, o.loadb, o.loadc, o.loads}, 5'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe cycle", o, e);
                end
            end
        end
    end

    // Accept one instruction and count rising edges until w returns; optional noise on s/in while busy.
    task automatic run(input string name, input logic [15:0] instr, input int exp_lat, input bit noise);
        int n;
        @(negedge clk);
        bus.in = instr;
        bus.s  = 1'b1;
        @(posedge clk);
        #1 bus.s = 1'b0;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            #1;
            if (noise && (n == 1 || n == 2)) begin
                bus.s  = 1'b1;
                bus.in = 16'hD105;
            end else if (noise && n == 3) begin
                bus.s  = 1'b0;
                bus.in = instr;
            end
            if (bus.w) break;
        end
        check(name, 64'(n), 64'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        bus.s  = 1'b0;
        bus.in = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Idle after reset: w high, no strobes, ir cleared.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 check("idle w", bus.w, 1'b1);
        end
        check("reset err", bus.err, 1'b0);
        check("reset sximm8", bus.sximm8, 16'h0000);

        // MOV R1,#5 and MOV R2,#-8
        set_ctx(16'h0005, 2'b00, 2'b10);
        exp_step(5'b10000, 3'd0, 3'd1, 1'b0, 2'b10);
        run("MOV imm #5 latency", 16'hD105, 2, 1'b0);
        set_ctx(16'hFFF8, 2'b11, 2'b10);
        exp_step(5'b10000, 3'd0, 3'd2, 1'b0, 2'b10);
        run("MOV imm #-8 latency", 16'hD2F8, 2, 1'b0);

        // ADD R5,R0,R1
        set_ctx(16'hFFA1, 2'b00, 2'b00);
        exp_step(5'b01000, 3'd0, 3'd0, 1'b0, 2'b00);
        exp_step(5'b00100, 3'd1, 3'd0, 1'b0, 2'b00);
        exp_step(5'b00010, 3'd0, 3'd0, 1'b0, 2'b00);
        exp_step(5'b10000, 3'd0, 3'd5, 1'b0, 2'b00);
        run("ADD latency", 16'hA0A1, 5, 1'b0);

        // CMP R1,R1: status load, no writeback
        set_ctx(16'h0001, 2'b00, 2'b01);
        exp_step(5'b01000, 3'd1, 3'd0, 1'b0, 2'b00);
        exp_step(5'b00100, 3'd1, 3'd0, 1'b0, 2'b00);
        exp_step(5'b00001, 3'd0, 3'd0, 1'b0, 2'b00);
        run("CMP latency", 16'hA901, 4, 1'b0);

        // MOV R7,R2
        set_ctx(16'hFFE2, 2'b00, 2'b00);
        exp_step(5'b00100, 3'd2, 3'd0, 1'b0, 2'b00);
        exp_step(5'b00010, 3'd0, 3'd0, 1'b1, 2'b00);
        exp_step(5'b10000, 3'd0, 3'd7, 1'b0, 2'b00);
        run("MOV reg latency", 16'hC0E2, 4, 1'b0);

        // MVN R5,R3
        set_ctx(16'hFFA3, 2'b00, 2'b11);
        exp_step(5'b00100, 3'd3, 3'd0, 1'b0, 2'b00);
        exp_step(5'b00010, 3'd0, 3'd0, 1'b0, 2'b00);
        exp_step(5'b10000, 3'd0, 3'd5, 1'b0, 2'b00);
        run("MVN latency", 16'hB8A3, 4, 1'b0);

        // AND R3,R2,R4 with shift code 10
        set_ctx(16'h0074, 2'b10, 2'b10);
        exp_step(5'b01000, 3'd2, 3'd0, 1'b0, 2'b00);
        exp_step(5'b00100, 3'd4, 3'd0, 1'b0, 2'b00);
        exp_step(5'b00010, 3'd0, 3'd0, 1'b0, 2'b00);
        exp_step(5'b10000, 3'd0, 3'd3, 1'b0, 2'b00);
        run("AND latency", 16'hB274, 5, 1'b0);

        // ADD with s/in toggling while busy: sequence must be the original ADD
        set_ctx(16'hFFA1, 2'b00, 2'b00);
        exp_step(5'b01000, 3'd0, 3'd0, 1'b0, 2'b00);
        exp_step(5'b00100, 3'd1, 3'd0, 1'b0, 2'b00);
        exp_step(5'b00010, 3'd0, 3'd0, 1'b0, 2'b00);
        exp_step(5'b10000, 3'd0, 3'd5, 1'b0, 2'b00);
        run("ADD busy-noise latency", 16'hA0A1, 5, 1'b1);
        check("post-noise w", bus.w, 1'b1);

        // Reset during GET_B of an ADD: only loada/loadb may be seen
        set_ctx(16'hFFA1, 2'b00, 2'b00);
        exp_step(5'b01000, 3'd0, 3'd0, 1'b0, 2'b00);
        exp_step(5'b00100, 3'd1, 3'd0, 1'b0, 2'b00);
        @(negedge clk);
        bus.in = 16'hA0A1;
        bus.s  = 1'b1;
        @(posedge clk);
        #1 bus.s = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("reset mid-op w", bus.w, 1'b1);
        check("reset mid-op write", bus.write, 1'b0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        check("reset mid-op ir", bus.sximm8, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check("post-reset w", bus.w, 1'b1);
        end

        // Undecodable opcode
`ifdef CPU_ILLEGAL_TRAP_EN
        @(negedge clk);
        bus.in = 16'h0000;
        bus.s  = 1'b1;
        @(posedge clk);
        #1 bus.s = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("trap err", bus.err, 1'b1);
        check("trap w", bus.w, 1'b0);
        bus.in = 16'hD105;
        bus.s  = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("trap ignores s w", bus.w, 1'b0);
        check("trap sticky err", bus.err, 1'b1);
        bus.s = 1'b0;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        #1 check("trap cleared err", bus.err, 1'b0);
        check("trap cleared w", bus.w, 1'b1);
`else
        run("NOP latency", 16'h0000, 1, 1'b0);
        check("NOP err", bus.err, 1'b0);
`endif

        repeat (3) @(posedge clk);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
